pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It merges the hazard unit's load-use/branch stall, ID-stage branch/jump redirects, instruction/data memory wait handshakes and the multi-cycle divider into one set of per-register enable and flush signals. It also runs the divider occupancy FSM and a stall-cycle performance counter. It sits between the hazard unit, the memories and the pipeline registers, and is the only block that drives pipeline-register enables and flushes.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_div_sequencer.sv | 75 +++++++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: divider FSM encoding and defaults.
package pipe_ctrl_defs;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam int unsigned DefDivCycles = 32;
  localparam int unsigned DefCntW      = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline environment (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             hazard_stall;
  logic             redirect;
  logic             div_in_ex;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             div_go;
  logic             div_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hazard_stall, redirect, div_in_ex, imem_req, imem_ready, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, div_go, div_done, stall_cnt
  );

  modport slave (
    input  hazard_stall, redirect, div_in_ex, imem_req, imem_ready, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, div_go, div_done, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_div_sequencer.sv
// Divider occupancy FSM: issues the start pulse, counts iterations and holds the result
// until the div instruction leaves EX.
module div_sequencer
  import pipe_ctrl_defs::*;
#(
  parameter int unsigned DIV_CYCLES = DefDivCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic i_div_in_ex,
  input  logic i_dwait,
  input  logic i_exmem_en,
  output logic o_dstall,
  output logic o_div_go,
  output logic o_div_done
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES);
  localparam logic [CntW-1:0] CntInit = CntW'(DIV_CYCLES - 1);

  div_state_e          r_state;
  div_state_e          w_state_nxt;
  logic     [CntW-1:0] r_cnt;
  logic     [CntW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_dstall = i_div_in_ex && (r_state != StDone);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_div_go    = 1'b0;
    o_div_done  = 1'b0;
    case (r_state)
      StIdle: begin
        // A memory wait holds the start so the divider never launches on a frozen pipeline.
        if (i_div_in_ex && !i_dwait) begin
          o_div_go    = 1'b1;
          w_cnt_nxt   = CntInit;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt == '0) begin
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StDone: begin
        o_div_done = 1'b1;
        if (i_exmem_en) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (rst) begin
      o_div_go   = 1'b0;
      o_div_done = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges memory waits, divider occupancy, hazard stalls and
// ID redirects into per-register enables/flushes, and counts front-end stall cycles.
module pipe_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int unsigned DIV_CYCLES = DefDivCycles,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic             w_dwait;
  logic             w_iwait;
  logic             w_dstall;
  logic             w_div_go;
  logic             w_div_done;
  logic             w_pc_en;
  logic             w_ifid_en;
  logic             w_idex_en;
  logic             w_exmem_en;
  logic             w_memwb_en;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic             w_exmem_flush;
  logic             w_kill_nxt;
  logic             r_fetch_kill;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_dwait = bus.dmem_req && !bus.dmem_ready;
  assign w_iwait = bus.imem_req && !bus.imem_ready;

  div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk         (clk),
    .rst         (rst),
    .i_div_in_ex (bus.div_in_ex),
    .i_dwait     (w_dwait),
    .i_exmem_en  (w_exmem_en),
    .o_dstall    (w_dstall),
    .o_div_go    (w_div_go),
    .o_div_done  (w_div_done)
  );

  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_kill_nxt    = r_fetch_kill;
    if (rst) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
      w_kill_nxt = 1'b0;
    end else if (w_dwait) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (w_dstall) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_flush = 1'b1;
    end else if (bus.hazard_stall) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (r_fetch_kill && bus.imem_ready) begin
      // The fetch issued before the redirect finally returned; discard it.
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
      w_kill_nxt   = 1'b0;
    end else if (bus.redirect) begin
      w_ifid_flush = 1'b1;
      if (w_iwait) begin
        w_kill_nxt = 1'b1;
      end
    end else if (w_iwait) begin
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_kill <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_fetch_kill <= w_kill_nxt;
      if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.idex_en     = w_idex_en;
  assign bus.exmem_en    = w_exmem_en;
  assign bus.memwb_en    = w_memwb_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.div_go      = w_div_go;
  assign bus.div_done    = w_div_done;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors with literal expectations plus a cycle-accurate
// behavioural model checked on every falling edge.
module tb_pipe_ctrl;

  localparam int unsigned DivCycles = 4;
  localparam int unsigned CntW      = 6;
  localparam logic [CntW-1:0] CntMax = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_ctrl #(
    .DIV_CYCLES (DivCycles),
    .CNT_W      (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  endfunction

  // Model: the divider result is ready DivCycles+1 cycles after its start pulse.
  int              m_cyc    = 0;
  int              m_start  = 0;
  bit              m_active = 1'b0;
  bit              m_kill   = 1'b0;
  logic [CntW-1:0] m_stall  = '0;

  always @(negedge clk) begin : model
    logic       dw, iw, done_now, dst, go, kill_n;
    logic [4:0] en;
    logic [2:0] fl;
    dw       = bus.dmem_req && !bus.dmem_ready;
    iw       = bus.imem_req && !bus.imem_ready;
    done_now = m_active && ((m_cyc - m_start) >= int'(DivCycles) + 1);
    dst      = bus.div_in_ex && !done_now;
    go       = !m_active && bus.div_in_ex && !dw;
    kill_n   = m_kill;
    en       = 5'b11111;
    fl       = 3'b000;
    if (rst) begin
      en = 5'b00000; go = 1'b0; done_now = 1'b0;
    end else if (dw) begin
      en = 5'b00000;
    end else if (dst) begin
      en = 5'b00011; fl = 3'b001;
    end else if (bus.hazard_stall) begin
      en = 5'b00111; fl = 3'b010;
    end else if (m_kill && bus.imem_ready) begin
      en = 5'b01111; fl = 3'b100; kill_n = 1'b0;
    end else if (bus.redirect) begin
      fl = 3'b100;
      if (iw) kill_n = 1'b1;
    end else if (iw) begin
      en = 5'b01111; fl = 3'b100;
    end
    chk("model_enables", 32'(en_vec()), 32'(en));
    chk("model_flushes", 32'(fl_vec()), 32'(fl));
    chk("model_div_go", 32'(bus.div_go), 32'(go));
    chk("model_div_done", 32'(bus.div_done), 32'(done_now));
    chk("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    if (rst) begin
      m_active = 1'b0; m_kill = 1'b0; m_stall = '0;
    end else begin
      if (done_now && en[1]) m_active = 1'b0;
      if (go) begin
        m_active = 1'b1; m_start = m_cyc;
      end
      m_kill = kill_n;
      if (!en[4] && m_stall != CntMax) m_stall = m_stall + 1'b1;
    end
    m_cyc++;
  end

  task automatic set_in(input logic hz, rd, dv, ir, iy, dr, dy);
    bus.hazard_stall = hz; bus.redirect = rd; bus.div_in_ex = dv;
    bus.imem_req = ir; bus.imem_ready = iy; bus.dmem_req = dr; bus.dmem_ready = dy;
  endtask

  task automatic observe();
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Mixed patterns, bit order {hazard, redirect, div, imem_req, imem_ready, dmem_req, dmem_ready}.
  logic [6:0] mix [16] = '{
    7'b0101000, 7'b0000010, 7'b0001110, 7'b0001000, 7'b0001100, 7'b1100000,
    7'b0100000, 7'b0010000, 7'b1010010, 7'b0010011, 7'b1010000, 7'b0110000,
    7'b0011000, 7'b0010000, 7'b0000000, 7'b0101100
  };

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    advance();
    observe();
    chk("rst_enables", 32'(en_vec()), 32'h0);
    chk("rst_flushes", 32'(fl_vec()), 32'h0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    advance();
    rst = 1'b0;
    observe();
    chk("idle_enables", 32'(en_vec()), 32'h1f);
    advance();

    set_in(1, 0, 0, 0, 0, 0, 0);
    observe();
    chk("hazard_enables", 32'(en_vec()), 32'h07);
    chk("hazard_flushes", 32'(fl_vec()), 32'h2);
    chk("hazard_cnt_before", 32'(bus.stall_cnt), 32'h0);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("hazard_cnt_after", 32'(bus.stall_cnt), 32'h1);
    advance();

    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 1, 0, 0, 0, 0);
      observe();
      chk("div_go_pulse", 32'(bus.div_go), 32'(k == 0));
      chk("div_exmem_flush", 32'(bus.exmem_flush), 32'(k < 5));
      chk("div_done_cycle", 32'(bus.div_done), 32'(k == 5));
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("div_back_idle", 32'(bus.div_done), 32'h0);
    chk("div_stall_cnt", 32'(bus.stall_cnt), 32'd6);
    advance();

    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 1, 0, 0, logic'(k == 2 || k == 3), 0);
      observe();
      if (k == 2 || k == 3) chk("div_dwait_frozen", 32'(en_vec()), 32'h0);
      chk("div_dwait_done", 32'(bus.div_done), 32'(k == 5));
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("div_dwait_cnt", 32'(bus.stall_cnt), 32'd11);
    advance();

    set_in(0, 1, 0, 1, 0, 0, 0);
    observe();
    chk("redir_pc_en", 32'(bus.pc_en), 32'h1);
    chk("redir_ifid_flush", 32'(bus.ifid_flush), 32'h1);
    advance();
    set_in(0, 0, 0, 1, 0, 0, 0);
    observe();
    chk("redir_wait_pc_en", 32'(bus.pc_en), 32'h0);
    advance();
    set_in(0, 0, 0, 1, 1, 0, 0);
    observe();
    chk("kill_drop_pc_en", 32'(bus.pc_en), 32'h0);
    chk("kill_drop_flush", 32'(bus.ifid_flush), 32'h1);
    advance();
    observe();
    chk("kill_cleared_pc_en", 32'(bus.pc_en), 32'h1);
    chk("kill_cleared_flush", 32'(bus.ifid_flush), 32'h0);
    chk("redir_stall_cnt", 32'(bus.stall_cnt), 32'd13);
    advance();

    set_in(1, 1, 0, 0, 0, 0, 0);
    observe();
    chk("redir_hz_pc_en", 32'(bus.pc_en), 32'h0);
    chk("redir_hz_flushes", 32'(fl_vec()), 32'h2);
    advance();
    set_in(0, 1, 0, 0, 0, 0, 0);
    observe();
    chk("redir_late_pc_en", 32'(bus.pc_en), 32'h1);
    chk("redir_late_flush", 32'(bus.ifid_flush), 32'h1);
    advance();

    set_in(0, 0, 1, 0, 0, 0, 0);
    advance();
    advance();
    rst = 1'b1;
    observe();
    chk("rst_busy_enables", 32'(en_vec()), 32'h0);
    chk("rst_busy_go", 32'(bus.div_go), 32'h0);
    chk("rst_busy_cnt_held", 32'(bus.stall_cnt), 32'd16);
    advance();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("rst_abort_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("rst_abort_done", 32'(bus.div_done), 32'h0);
    advance();
    set_in(0, 0, 1, 0, 0, 0, 0);
    observe();
    chk("rst_abort_restart", 32'(bus.div_go), 32'h1);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) advance();

    for (int k = 0; k < 16; k++) begin
      set_in(mix[k][6], mix[k][5], mix[k][4], mix[k][3], mix[k][2], mix[k][1], mix[k][0]);
      advance();
    end

    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 70; k++) advance();
    observe();
    chk("stall_cnt_saturated", 32'(bus.stall_cnt), 32'(CntMax));
    advance();
    observe();
    chk("stall_cnt_holds", 32'(bus.stall_cnt), 32'(CntMax));
    set_in(0, 0, 0, 0, 0, 0, 0);
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
